// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem requests, one held instruction, next-PC on retire.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a FAULT state for misaligned next-PC / flush targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        pc_src,
  input  logic [31:0] imm_ext,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_VALID
`ifdef FETCH_MISALIGN_TRAP_EN
    , S_FAULT
`endif
  } state_t;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFF;
  localparam state_t      MIS_STATE  = S_FAULT;
`else
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam state_t      MIS_STATE  = S_REQ;
`endif

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        kill_q, kill_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;

  logic [31:0] npc, npc_tgt, flush_tgt;
  logic        npc_bad, flush_bad, fetch_bad;

  always_comb begin
    npc       = pc_q + (pc_src ? imm_ext : 32'd4);
    npc_tgt   = npc & ALIGN_MASK;
    flush_tgt = flush_pc & ALIGN_MASK;
`ifdef FETCH_MISALIGN_TRAP_EN
    npc_bad   = (npc_tgt[1:0] != 2'b00);
    flush_bad = (flush_tgt[1:0] != 2'b00);
    fetch_bad = (fetch_pc_q[1:0] != 2'b00);
`else
    npc_bad   = 1'b0;
    flush_bad = 1'b0;
    fetch_bad = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    kill_d       = kill_q;

    if (state_q == S_BOOT) begin
      fetch_pc_d = RESET_PC;
      state_d    = S_REQ;
    end else if (flush) begin
      fetch_pc_d   = flush_tgt;
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
      state_d      = flush_bad ? MIS_STATE : S_REQ;
      // A granted request is still in flight; its response must be dropped.
      if (state_q == S_REQ && imem_gnt) begin
        kill_d  = 1'b1;
        state_d = S_WAIT;
      end else if (state_q == S_WAIT) begin
        if (imem_rvalid) begin
          kill_d = 1'b0;
        end else begin
          kill_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_gnt) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = fetch_bad ? MIS_STATE : S_REQ;
            end else begin
              inst_d       = imem_rdata;
              pc_d         = fetch_pc_q;
              inst_valid_d = 1'b1;
              state_d      = S_VALID;
            end
          end
        end
        S_VALID: begin
          if (inst_ready) begin
            fetch_pc_d   = npc_tgt;
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
            state_d      = npc_bad ? MIS_STATE : S_REQ;
          end
        end
        default: ;
      endcase
    end

    imem_req_d  = (state_d == S_REQ);
    imem_addr_d = fetch_pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      fetch_pc_q   <= RESET_PC;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
      kill_q       <= 1'b0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      kill_q       <= kill_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign fault_d = (state_d == S_FAULT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst       = inst_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + 32'd4;
  assign inst_valid = inst_valid_q;

endmodule
